// File: rtl/addsub_pipe.sv
// addsub_pipe: chunked, carry-pipelined adder/subtractor with valid/ready
// handshaking on both sides.
//
// Rank 0 captures the operands. It holds a and the effective b (b already
// inverted for subtraction), with sub as the carry-in. Stage k then adds
// chunk k and writes the result into the next rank. Each rank carries one
// merged vector: the sum chunks completed so far sit in the low bits, and
// the operand chunks still waiting to be added sit in the high bits.
// The whole pipeline advances together whenever the output is free or
// being drained.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

  // Rank r holds the transaction after r chunks have been added.
  // Rank STAGES is the presented result.
  logic             r_v   [0:STAGES];
  logic [WIDTH-1:0] r_x   [0:STAGES];
  logic [WIDTH-1:0] r_y   [0:STAGES-1];
  logic             r_c   [0:STAGES];
  logic             r_sub [0:STAGES];
  logic             r_ovf;
  logic             r_yneg;

  logic [CHUNK-1:0] w_sum [0:STAGES-1];
  logic             w_co  [0:STAGES-1];
  logic [WIDTH-1:0] w_xn  [0:STAGES-1];
  logic [WIDTH-1:0] w_beff;
  logic             w_cmsb;
  logic             w_ovf;
  logic             w_en;

  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v[STAGES];
  assign w_beff    = b ^ {WIDTH{sub}};

  // Per-stage chunk adders; each one splices its sum chunk into the merged vector.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      {w_co[k], w_sum[k]} = {1'b0, r_x[k][k*CHUNK +: CHUNK]}
                          + {1'b0, r_y[k][k*CHUNK +: CHUNK]}
                          + {{CHUNK{1'b0}}, r_c[k]};
      w_xn[k] = r_x[k];
      w_xn[k][k*CHUNK +: CHUNK] = w_sum[k];
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  assign w_cmsb = w_sum[STAGES-1][CHUNK-1] ^ r_x[STAGES-1][WIDTH-1]
                ^ r_y[STAGES-1][WIDTH-1];
  assign w_ovf  = w_cmsb ^ w_co[STAGES-1];

  // Pipeline ranks: capture on accept, shift everything when enabled, clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k <= STAGES; k++) begin
        r_v[k]   <= 1'b0;
        r_x[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_sub[k] <= 1'b0;
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_y[k] <= '0;
      end
      r_ovf  <= 1'b0;
      r_yneg <= 1'b0;
    end else if (w_en) begin
      r_v[0]   <= in_valid;
      r_x[0]   <= a;
      r_y[0]   <= w_beff;
      r_c[0]   <= sub;
      r_sub[0] <= sub;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_v[k+1]   <= r_v[k];
        r_x[k+1]   <= w_xn[k];
        r_c[k+1]   <= w_co[k];
        r_sub[k+1] <= r_sub[k];
      end
      for (int unsigned k = 0; k + 1 < STAGES; k++) begin
        r_y[k+1] <= r_y[k];
      end
      r_ovf  <= w_ovf;
      r_yneg <= r_y[STAGES-1][WIDTH-1];
    end
  end

  assign cout = r_sub[STAGES] ^ r_c[STAGES];
  assign ovf  = r_ovf;

  // Result, clamped toward the sign of the effective b when saturating on overflow.
  always_comb begin
    s = r_x[STAGES];
    if ((SAT != 0) && r_ovf) begin
      s = r_yneg ? NEG_LIM : POS_LIM;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, CHUNK=4), with one plain
// instance and one saturating instance sharing the same stimulus.
module tb_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready_sat;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_valid_sat;
  logic        out_ready;
  logic [15:0] s;
  logic [15:0] s_sat;
  logic        cout;
  logic        cout_sat;
  logic        ovf;
  logic        ovf_sat;

  addsub_pipe #(.WIDTH(16), .CHUNK(4), .SAT(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  addsub_pipe #(.WIDTH(16), .CHUNK(4), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sat),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_sat), .out_ready(out_ready),
    .s(s_sat), .cout(cout_sat), .ovf(ovf_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic [15:0] s_sat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic [15:0] s_sat;
  } vec_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic msub);
    exp_t e;
    int sa;
    int sb;
    int r;
    int unsigned ua;
    int unsigned ub;
    sa = $signed(ma);
    sb = $signed(mb);
    ua = ma;
    ub = mb;
    r  = msub ? (sa - sb) : (sa + sb);
    e.s    = r[15:0];
    e.cout = msub ? (ua < ub) : ((ua + ub) > 32'h0000_FFFF);
    e.ovf  = (r > 32767) || (r < -32768);
    e.s_sat = e.ovf ? ((r > 0) ? 16'h7FFF : 16'h8000) : e.s;
    return e;
  endfunction

  // Scoreboard monitor: record accepts, check results and stall stability.
  logic        hold_prev = 1'b0;
  logic [15:0] prev_s;
  logic [15:0] prev_ss;
  logic        prev_c;
  logic        prev_o;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_s", s, prev_s);
        chk("hold_s_sat", s_sat, prev_ss);
        chk("hold_cout", cout, prev_c);
        chk("hold_ovf", ovf, prev_o);
      end
      chk("sat_out_valid", out_valid_sat, out_valid);
      chk("sat_in_ready", in_ready_sat, in_ready);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_s", s, e.s);
          chk("sb_cout", cout, e.cout);
          chk("sb_ovf", ovf, e.ovf);
          chk("sb_s_sat", s_sat, e.s_sat);
          chk("sb_cout_sat", cout_sat, e.cout);
          chk("sb_ovf_sat", ovf_sat, e.ovf);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, sub));
      hold_prev = out_valid && !out_ready;
      prev_s  = s;
      prev_ss = s_sat;
      prev_c  = cout;
      prev_o  = ovf;
    end
  end

  // Offer one operand set, wait for its accept, then count cycles to out_valid.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tsub,
                       output int lat);
    int   tries;
    logic acc;
    tries = 0;
    acc   = 1'b0;
    @(posedge clk); #1;
    a = ta; b = tbv; sub = tsub; in_valid = 1'b1;
    while (!acc && tries < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 1'b0;
    chk("accept", acc, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   lat;
    int   stall_seen;
    int   n;
    logic acc_last;
    logic [15:0] sa_ops [8];
    logic [15:0] sb_ops [8];
    logic        ss_ops [8];

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 16'h2233};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'hFFFE};
    vecs[2] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0002};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h7FFF};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 16'h8000};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[6] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b1, 16'h7FFF};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk("vec_latency", lat, 4);
      chk("vec_out_valid", out_valid, 1);
      chk("vec_s", s, vecs[i].s);
      chk("vec_cout", cout, vecs[i].cout);
      chk("vec_ovf", ovf, vecs[i].ovf);
      chk("vec_s_sat", s_sat, vecs[i].s_sat);
      chk("vec_ovf_sat", ovf_sat, vecs[i].ovf);
    end

    // Eight back-to-back operations with a 3-cycle output stall
    for (int i = 0; i < 8; i++) begin
      sa_ops[i] = rnd_val();
      sb_ops[i] = rnd_val();
      ss_ops[i] = 1'($urandom_range(0, 1));
    end
    stall_seen = 0;
    begin
      int i;
      int cyc;
      i = 0;
      cyc = 0;
      while (i < 8 && cyc < 100) begin
        @(posedge clk); #1;
        out_ready = !(cyc >= 6 && cyc < 9);
        in_valid = 1'b1;
        a = sa_ops[i]; b = sb_ops[i]; sub = ss_ops[i];
        @(negedge clk);
        if (out_valid && !out_ready) begin
          stall_seen++;
          chk("stall_in_ready", in_ready, 0);
        end
        if (in_ready) i++;
        cyc++;
      end
      chk("stream_all_accepted", i, 8);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stream_drained", q.size(), 0);
    chk("stream_stall_seen", (stall_seen > 0), 1);

    // Reset with three operations in flight
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      a = rnd_val(); b = rnd_val(); sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_s", s, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midrst_idle_out_valid", out_valid, 0);
    end
    do_op(16'h1234, 16'h0FFF, 1'b0, lat);
    chk("midrst_latency", lat, 4);
    chk("midrst_s", s, 16'h2233);
    chk("midrst_cout", cout, 0);

    // Randomized valid/ready traffic against the scoreboard
    acc_last = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a = rnd_val();
        b = rnd_val();
        sub = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc_last = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("random_drained", q.size(), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("final_idle_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
